// File: rtl/alu_operand_sequencer_pkg.sv
// Shared constants for the ALU operand sequencer: instruction fields,
// opcode/funct codes, ALU operation codes and FSM states.
package alu_operand_sequencer_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  typedef enum logic [5:0] {
    ALU_NOP = 6'd0,
    ALU_ADD = 6'd1,
    ALU_SUB = 6'd2,
    ALU_MUL = 6'd3,
    ALU_SRL = 6'd4,
    ALU_SLL = 6'd5,
    ALU_AND = 6'd6,
    ALU_OR  = 6'd7,
    ALU_NOR = 6'd8,
    ALU_SLT = 6'd9
  } alu_oprn_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// 32-entry register file: two operand reads, one debug read, one write.
// Register 0 reads as zero and ignores writes.
module alu_seq_regfile
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_a,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_b,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0]     rdata_a,
  output logic [DATA_WIDTH-1:0]     rdata_b,
  output logic [DATA_WIDTH-1:0]     dbg_rdata,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = (raddr_a   == '0) ? '0 : mem[raddr_a];
  assign rdata_b   = (raddr_b   == '0) ? '0 : mem[raddr_b];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem[dbg_raddr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue/writeback sequencer around an external combinational ALU:
// IDLE -> DECODE -> EXEC -> WB, one instruction per four cycles.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OPRN_WIDTH     = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               INSTR,
  input  logic                      INSTR_VALID,
  output logic                      INSTR_READY,
  output logic [DATA_WIDTH-1:0]     ALU_OP1,
  output logic [DATA_WIDTH-1:0]     ALU_OP2,
  output logic [OPRN_WIDTH-1:0]     ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]     ALU_RESULT,
  input  logic                      ALU_ZERO,
  output logic                      DONE,
  output logic [DATA_WIDTH-1:0]     RESULT,
  output logic                      ZERO_FLAG,
  output logic                      ILLEGAL,
  input  logic [REG_ADDR_WIDTH-1:0] DBG_RADDR,
  output logic [DATA_WIDTH-1:0]     DBG_RDATA
);

  seq_state_e state, state_nx;

  logic [31:0]               instr_q;
  logic [DATA_WIDTH-1:0]     op1_q, op2_q, result_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  alu_oprn_e                 oprn_q;
  logic                      zero_q;

  logic [DATA_WIDTH-1:0]     rdata_a, rdata_b;
  logic [5:0]                opc, funct;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic [4:0]                shamt;
  logic [15:0]               imm;

  logic                      dec_legal;
  alu_oprn_e                 dec_oprn;
  logic [DATA_WIDTH-1:0]     dec_op2;
  logic [REG_ADDR_WIDTH-1:0] dec_dest;

  assign opc   = instr_q[OPC_HI:OPC_LO];
  assign rs    = instr_q[RS_HI:RS_LO];
  assign rt    = instr_q[RT_HI:RT_LO];
  assign rd    = instr_q[RD_HI:RD_LO];
  assign shamt = instr_q[SH_HI:SH_LO];
  assign funct = instr_q[FN_HI:FN_LO];
  assign imm   = instr_q[IMM_HI:IMM_LO];

  alu_seq_regfile #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk      (CLK),
    .rst      (RST),
    .raddr_a  (rs),
    .raddr_b  (rt),
    .dbg_raddr(DBG_RADDR),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_rdata(DBG_RDATA),
    .we       (state == S_WB),
    .waddr    (dest_q),
    .wdata    (result_q)
  );

  always_comb begin
    dec_legal = 1'b1;
    dec_oprn  = ALU_NOP;
    dec_op2   = rdata_b;
    dec_dest  = rt;
    case (opc)
      OPC_RTYPE: begin
        dec_dest = rd;
        case (funct)
          FN_ADD: dec_oprn = ALU_ADD;
          FN_SUB: dec_oprn = ALU_SUB;
          FN_MUL: dec_oprn = ALU_MUL;
          FN_AND: dec_oprn = ALU_AND;
          FN_OR:  dec_oprn = ALU_OR;
          FN_NOR: dec_oprn = ALU_NOR;
          FN_SLT: dec_oprn = ALU_SLT;
          FN_SRL: begin
            dec_oprn = ALU_SRL;
            dec_op2  = DATA_WIDTH'(shamt);
          end
          FN_SLL: begin
            dec_oprn = ALU_SLL;
            dec_op2  = DATA_WIDTH'(shamt);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      // Arithmetic immediates sign-extend, logical ones zero-extend
      OPC_ADDI: begin
        dec_oprn = ALU_ADD;
        dec_op2  = DATA_WIDTH'($signed(imm));
      end
      OPC_MULI: begin
        dec_oprn = ALU_MUL;
        dec_op2  = DATA_WIDTH'($signed(imm));
      end
      OPC_SLTI: begin
        dec_oprn = ALU_SLT;
        dec_op2  = DATA_WIDTH'($signed(imm));
      end
      OPC_ANDI: begin
        dec_oprn = ALU_AND;
        dec_op2  = DATA_WIDTH'(imm);
      end
      OPC_ORI: begin
        dec_oprn = ALU_OR;
        dec_op2  = DATA_WIDTH'(imm);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      instr_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      oprn_q   <= ALU_NOP;
      dest_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) instr_q <= INSTR;
        end
        S_DECODE: begin
          op1_q  <= rdata_a;
          op2_q  <= dec_op2;
          oprn_q <= dec_oprn;
          dest_q <= dec_dest;
        end
        S_EXEC: begin
          result_q <= ALU_RESULT;
          zero_q   <= ALU_ZERO;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    INSTR_READY = 1'b0;
    DONE        = 1'b0;
    ILLEGAL     = 1'b0;
    case (state)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) state_nx = S_DECODE;
      end
      S_DECODE: begin
        ILLEGAL  = ~dec_legal;
        state_nx = dec_legal ? S_EXEC : S_IDLE;
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        DONE     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign ALU_OP1   = (state == S_EXEC) ? op1_q : '0;
  assign ALU_OP2   = (state == S_EXEC) ? op2_q : '0;
  assign ALU_OPRN  = (state == S_EXEC) ? OPRN_WIDTH'(oprn_q) : '0;
  assign RESULT    = result_q;
  assign ZERO_FLAG = zero_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Multi-cycle issue/writeback stage wrapped around the combinational ALU (OUT/ZERO/OP1/OP2/OPRN interface, 32-bit data, 6-bit operation code).
- Accepts one MIPS-style R/I-type instruction per handshake.
- Reads operands from an internal 32x32 register file and maps the instruction onto the ALU operation code (1..9).
- Drives the external ALU, captures OUT/ZERO and writes the result back to the register file.
- Sits directly upstream of the ALU (feeds OP1/OP2/OPRN) and consumes its result.

Parameters:
DATA_WIDTH, 32, width of register, operand and result words
REG_ADDR_WIDTH, 5, register file address width (2**5 = 32 entries)
OPRN_WIDTH, 6, width of the ALU operation code

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
INSTR  in  32  instruction word
INSTR_VALID  in  1  instruction present
INSTR_READY  out  1  block can accept an instruction
ALU_OP1  out  32  ALU operand 1
ALU_OP2  out  32  ALU operand 2
ALU_OPRN  out  6  ALU operation code
ALU_RESULT  in  32  ALU OUT
ALU_ZERO  in  1  ALU ZERO
DONE  out  1  one-cycle pulse: instruction retired
RESULT  out  32  value written back; held until next DONE
ZERO_FLAG  out  1  captured ALU_ZERO; held until next DONE
ILLEGAL  out  1  one-cycle pulse: undecodable instruction dropped
DBG_RADDR  in  5  debug read address
DBG_RDATA  out  32  combinational read of register DBG_RADDR

Behaviour:
- Reset state: FSM in IDLE; all 32 registers cleared to 0.
- Outputs after reset: INSTR_READY=1; ALU_OP1/ALU_OP2=0, ALU_OPRN=0; DONE=0, ILLEGAL=0; RESULT=0, ZERO_FLAG=0.
- FSM IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY, latch INSTR and go to DECODE. INSTR is ignored in every other state.
- DECODE: read rs=INSTR[25:21], rt=INSTR[20:16]; build operands and opcode into registers.
  - Illegal instruction: pulse ILLEGAL, no writeback, return to IDLE.
- Legal R-type decode (opcode 6'h00), dest=rd[15:11]:
  - add 0x20->1; sub 0x22->2; mul 0x2c->3; and 0x24->6; or 0x25->7; nor 0x27->8; slt 0x2a->9. For these: OP1=R[rs], OP2=R[rt].
  - srl 0x02->4, sll 0x01->5: OP1=R[rs], OP2=zero-extended shamt[10:6].
- Legal I-type decode, dest=rt, imm=INSTR[15:0]:
  - addi 0x08->1; muli 0x1d->3; slti 0x0a->9 (imm sign-extended).
  - andi 0x0c->6; ori 0x0d->7 (imm zero-extended).
  - OP1=R[rs], OP2=extended imm.
- Any other opcode/funct combination is illegal.
- EXEC: ALU_OP1/ALU_OP2/ALU_OPRN driven from registers. ALU is combinational; ALU_RESULT/ALU_ZERO are sampled at the end of this cycle into RESULT and ZERO_FLAG.
- WB: write RESULT to R[dest] unless dest==0; pulse DONE.
- ALU_OPRN/ALU_OP1/ALU_OP2 return to 0 outside EXEC.
- Latency: accepted at edge t -> DONE high in cycle t+3; writeback visible on DBG_RDATA from t+4. Throughput one instruction per 4 cycles.
- R0 always reads 0; writes to R0 are discarded but DONE/RESULT still update.
- Read-after-write: the next instruction's DECODE occurs after the prior WB edge, so no bypass is needed.
- Arithmetic: 32-bit wrap-around, no overflow flag; the ALU defines mul (low 32 bits) and slt semantics.
- RST in any state (mid-instruction): in-flight instruction discarded, no writeback, all state returns to reset values on that edge.

Decomposition:
- Shared package/include:
  - instruction field index constants;
  - opcode/funct codes;
  - ALU operation codes 1..9, shared with the ALU and its bench;
  - FSM state encodings.
- One sub-module: alu_seq_regfile. 32x32 storage, 2 read ports + debug read, 1 write port, synchronous reset, R0 hardwired 0.

Test Plan:
1. Reset, then addi r1,r0,-15 and addi r2,r0,3, then add r3,r1,r2 -> third DONE 3 cycles after its accept, RESULT=32'hFFFFFFF4 (-12), DBG r3=-12, ZERO_FLAG=0.
2. r1=20, r2=20, then sub r4,r1,r2 -> RESULT=0, ZERO_FLAG=1. Then slt r5,r2,r1 -> 0; slti r5,r1,21 -> 1.
3. r1=18, then srl r6,r1,5 -> 0; sll r6,r1,2 -> 72. nor r7,r0,r0 -> 32'hFFFFFFFF. andi r8,r7,16'hFFFF -> 32'h0000FFFF (zero-extend check).
4. INSTR_VALID held high with back-to-back instructions -> INSTR_READY low in DECODE/EXEC/WB, exactly one accept per 4 cycles, no instruction lost or duplicated.
5. Opcode 6'h3f -> ILLEGAL pulse, no DONE, registers unchanged. Also add r0,r1,r1 -> DONE, RESULT=2*r1, but r0 still reads 0.
6. Assert RST during EXEC of add r3,r1,r2 -> no DONE; r3 (and all registers) =0; INSTR_READY=1 the cycle after reset deasserts.
